// File: rtl/knn_pkg.sv
// Shared sizing, FSM state encoding and vector type for the kNN controller.
package knn_pkg;

  localparam int NUM_COL  = 8;
  localparam int VECT_LEN = 4;
  localparam int WORD_LEN = 6;
  localparam int SUM_LEN  = 10;
  localparam int LBL_LEN  = 10;
  localparam int PIPE_LAT = 4;

  localparam int IDX_W = $clog2(NUM_COL);
  localparam int CNT_W = $clog2(NUM_COL + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    SCAN,
    DONE
  } state_t;

  typedef logic [VECT_LEN-1:0][WORD_LEN-1:0] vec_t;

  function automatic logic [NUM_COL-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/knn_min_sel.sv
// Running-minimum register: the first sample loads unconditionally, later ones only
// replace it when strictly smaller, so the earliest column wins a tie.
module knn_min_sel
  import knn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_first,
  input  logic               i_valid,
  input  logic [SUM_LEN-1:0] i_dist,
  input  logic [LBL_LEN-1:0] i_lbl,
  output logic [SUM_LEN-1:0] o_min_dist,
  output logic [LBL_LEN-1:0] o_min_lbl
);

  logic [SUM_LEN-1:0] r_min_dist;
  logic [LBL_LEN-1:0] r_min_lbl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_min_dist <= '0;
      r_min_lbl  <= '0;
    end else if (i_valid && (i_first || (i_dist < r_min_dist))) begin
      r_min_dist <= i_dist;
      r_min_lbl  <= i_lbl;
    end
  end

  assign o_min_dist = r_min_dist;
  assign o_min_lbl  = r_min_lbl;

endmodule

// File: rtl/knn_ctrl.sv
// Sequencer for the kNN sum-column array: loads training columns, runs a 1-NN query scan.
// Optional KNN_CTRL_REPLACE_EN: when full, keep accepting and overwrite columns oldest-first.
module knn_ctrl
  import knn_pkg::*;
#(
  parameter int LAT = PIPE_LAT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            trn_valid,
  output logic                            trn_ready,
  input  vec_t                            trn_vec,
  input  logic [LBL_LEN-1:0]              trn_lbl,
  input  logic                            qry_valid,
  output logic                            qry_ready,
  input  vec_t                            qry_vec,
  output logic [NUM_COL-1:0]              col_we,
  output vec_t                            col_vec,
  output logic [LBL_LEN-1:0]              col_lbl,
  input  logic [NUM_COL-1:0][SUM_LEN-1:0] col_sum,
  input  logic [NUM_COL-1:0][LBL_LEN-1:0] col_lblo,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [LBL_LEN-1:0]              res_lbl,
  output logic [SUM_LEN-1:0]              res_dist,
  output logic [CNT_W-1:0]                n_trained
);

  localparam int LAT_W = (LAT < 2) ? 1 : $clog2(LAT);

  state_t             r_state;
  logic [CNT_W-1:0]   r_n_trained;
  logic [IDX_W-1:0]   r_wptr;
  logic [IDX_W-1:0]   r_idx;
  logic [LAT_W-1:0]   r_wcnt;
  logic [NUM_COL-1:0] r_col_we;
  vec_t               r_col_vec;
  logic [LBL_LEN-1:0] r_col_lbl;
  logic               r_res_valid;
  logic [LBL_LEN-1:0] r_res_lbl;
  logic [SUM_LEN-1:0] r_res_dist;

  logic               w_room;
  logic               w_last;
  logic               w_scan;
  logic [SUM_LEN-1:0] w_min_dist;
  logic [LBL_LEN-1:0] w_min_lbl;

`ifdef KNN_CTRL_REPLACE_EN
  assign w_room = 1'b1;
`else
  assign w_room = (r_n_trained < CNT_W'(NUM_COL));
`endif

  // Ready is gated by rst so both handshakes stay closed while reset is held.
  assign trn_ready = !rst && (r_state == IDLE) && w_room;
  assign qry_ready = !rst && (r_state == IDLE) && (r_n_trained != '0) && !trn_valid;

  assign w_scan = (r_state == SCAN);
  assign w_last = (r_idx == IDX_W'(r_n_trained - CNT_W'(1)));

  knn_min_sel u_min_sel (
    .clk       (clk),
    .rst       (rst),
    .i_first   (r_idx == '0),
    .i_valid   (w_scan),
    .i_dist    (col_sum[r_idx]),
    .i_lbl     (col_lblo[r_idx]),
    .o_min_dist(w_min_dist),
    .o_min_lbl (w_min_lbl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_n_trained <= '0;
      r_wptr      <= '0;
      r_idx       <= '0;
      r_wcnt      <= '0;
      r_col_we    <= '0;
      r_col_vec   <= '0;
      r_col_lbl   <= '0;
      r_res_valid <= 1'b0;
      r_res_lbl   <= '0;
      r_res_dist  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (trn_valid && trn_ready) begin
            r_col_vec <= trn_vec;
            r_col_lbl <= trn_lbl;
            r_col_we  <= onehot(r_wptr);
            r_state   <= LOAD;
          end else if (qry_valid && qry_ready) begin
            r_col_vec <= qry_vec;
            r_wcnt    <= '0;
            r_idx     <= '0;
            r_state   <= (LAT == 0) ? SCAN : WAIT;
          end
        end
        LOAD: begin
          r_col_we <= '0;
          // Write pointer walks the columns in order, so after wrapping it targets the oldest.
          r_wptr   <= (r_wptr == IDX_W'(NUM_COL - 1)) ? '0 : r_wptr + IDX_W'(1);
          if (r_n_trained < CNT_W'(NUM_COL)) begin
            r_n_trained <= r_n_trained + CNT_W'(1);
          end
          r_state <= IDLE;
        end
        WAIT: begin
          if (r_wcnt == LAT_W'(LAT - 1)) begin
            r_state <= SCAN;
          end else begin
            r_wcnt <= r_wcnt + LAT_W'(1);
          end
        end
        SCAN: begin
          if (w_last) begin
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (!r_res_valid) begin
            r_res_valid <= 1'b1;
            r_res_lbl   <= w_min_lbl;
            r_res_dist  <= w_min_dist;
          end else if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign col_we    = r_col_we;
  assign col_vec   = r_col_vec;
  assign col_lbl   = r_col_lbl;
  assign res_valid = r_res_valid;
  assign res_lbl   = r_res_lbl;
  assign res_dist  = r_res_dist;
  assign n_trained = r_n_trained;

endmodule
